// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer
// Buffers (x, y, last) operand pairs in a small FIFO and streams them into an
// attached MAC one pair per cycle. The MAC is cleared before each vector. Once
// the last product has settled, the accumulated value and the pair count are
// returned over a valid/ready result handshake.
module mac_operand_sequencer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_last,
  output logic [WIDTH-1:0] mac_x,
  output logic [WIDTH-1:0] mac_y,
  output logic             mac_clear,
  input  logic [WIDTH-1:0] mac_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_mac,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = 2 * WIDTH + 1;
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state_reg;
  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      level_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             mac_clear_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_mac_reg;
  logic [CNT_W-1:0] out_count_reg;

  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic [EW-1:0]    head;
  logic [WIDTH-1:0] head_x;
  logic [WIDTH-1:0] head_y;
  logic             head_last;

  assign empty     = (level_reg == '0);
  assign full      = (level_reg == FULL_LEVEL);
  // Ready is masked while reset is held; a full FIFO never takes a push,
  // even if the head is leaving in the same cycle.
  assign in_ready  = reset && !full;
  assign push      = in_valid && in_ready;
  // Only RUN consumes entries; DONE leaves the next vector waiting in the FIFO.
  assign pop       = (state_reg == RUN) && !empty;

  assign head      = mem[rd_ptr_reg];
  assign head_x    = head[EW-1:WIDTH+1];
  assign head_y    = head[WIDTH:1];
  assign head_last = head[0];

  // Zero operands during bubbles and idle keep the MAC accumulator unchanged.
  assign mac_x     = pop ? head_x : '0;
  assign mac_y     = pop ? head_y : '0;

  assign mac_clear = mac_clear_reg;
  assign out_valid = out_valid_reg;
  assign out_mac   = out_mac_reg;
  assign out_count = out_count_reg;
  assign busy      = (state_reg != IDLE);

  // FIFO storage: payload only, so it needs no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_reg] <= {in_x, in_y, in_last};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Vector sequencing FSM with registered clear pulse and result outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      mac_clear_reg <= 1'b0;
      out_valid_reg <= 1'b0;
      out_mac_reg   <= '0;
      out_count_reg <= '0;
    end else begin
      mac_clear_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // Looking at the incoming push as well saves a cycle of start-up latency.
          if (!empty || push) begin
            state_reg     <= CLEAR;
            mac_clear_reg <= 1'b1;
          end
        end
        CLEAR: begin
          cnt_reg   <= '0;
          state_reg <= RUN;
        end
        RUN: begin
          if (pop) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (head_last) begin
              state_reg <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // The MAC registered the last product on the previous edge.
          out_mac_reg   <= mac_in;
          out_count_reg <= cnt_reg;
          out_valid_reg <= 1'b1;
          state_reg     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mac_operand_sequencer.md
Name: mac_operand_sequencer

Overview:
- Initiator-side companion to the MMIO MAC black box.
- Accepts a stream of (x, y) operand pairs over a valid/ready handshake and buffers them in a small FIFO.
- Drives the pairs into the MAC's x/y inputs one per cycle, and clears the MAC before each vector.
- After the MAC settles, captures the MAC's accumulated output and returns it, with the pair count, over an output valid/ready handshake.

Parameters:
- WIDTH, 32, operand and accumulator width; must match the attached MAC.
- DEPTH, 4, operand FIFO entries; power of two, >= 2.
- CNT_W, 16, width of the per-vector pair counter.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO can accept a pair.
- in_x  in  WIDTH  operand x.
- in_y  in  WIDTH  operand y.
- in_last  in  1  marks the final pair of a vector.
- mac_x  out  WIDTH  to MAC x.
- mac_y  out  WIDTH  to MAC y.
- mac_clear  out  1  to MAC synchronous reset; one-cycle pulse.
- mac_in  in  WIDTH  MAC accumulated result (MAC registers mac + x*y every cycle).
- out_valid  out  1  result valid.
- out_ready  in  1  result accepted.
- out_mac  out  WIDTH  captured dot product.
- out_count  out  CNT_W  pairs in the vector.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset==0, async):
  - State IDLE; FIFO empty.
  - in_ready=0 while reset is held, 1 after release.
  - mac_x=mac_y=0, mac_clear=0, out_valid=0, out_mac=0, out_count=0, busy=0, internal counter=0.
- FIFO:
  - Push when in_valid && in_ready; in_ready = !full, in every state.
  - No bypass: a full FIFO refuses a push even when a pop occurs in the same cycle.
  - Stores {x, y, last}; pointers wrap modulo DEPTH.
- mac_x/mac_y:
  - Combinational from the FIFO head while state==RUN and the FIFO is non-empty.
  - Forced to 0 otherwise, so the MAC accumulator holds its value during bubbles and idle.
- States:
  - IDLE: if FIFO non-empty -> CLEAR.
  - CLEAR: mac_clear=1 for exactly this cycle; counter<=0; -> RUN.
  - RUN: if FIFO non-empty, pop the head (drive it to the MAC) and counter<=counter+1. If the popped entry has last=1 -> DRAIN. If FIFO empty: bubble with zeros, stay in RUN.
  - DRAIN: mac_in now reflects the last product. Capture out_mac<=mac_in and out_count<=counter; -> DONE.
  - DONE: out_valid=1 and outputs held stable. On out_ready -> IDLE with out_valid=0 in the next cycle. Pairs of the next vector may be pushed meanwhile; none are popped.
- Latency:
  - First pair pushed at cycle t into an empty, idle block: CLEAR at t+1, popped at t+2.
  - Last pair popped at cycle p: out_valid=1 at p+2.
- Arithmetic:
  - Product and sum are computed in the MAC; out_mac is its WIDTH-bit value and wraps modulo 2^WIDTH.
  - Counter wraps modulo 2^CNT_W.
- Boundary cases:
  - A single-pair vector (first pair last=1) is legal.
  - in_last is only honoured on popped entries.
  - Async reset mid-vector discards FIFO contents, the count and the pending result; no out_valid is produced for that vector.
  - out_ready while out_valid=0 is ignored.

Test Plan:
- Vector (2,3),(4,5),(1,7,last) pushed back-to-back after reset -> mac_clear pulses once; out_mac=33, out_count=3; out_valid exactly 2 cycles after the last pop.
- Single pair (6,7,last) -> out_mac=42, out_count=1.
- Push 6 pairs (all 1x1, last on the 6th) with DEPTH=4 while holding off the pop side -> in_ready drops after 4 entries, no pair lost or duplicated; out_mac=6, out_count=6.
- in_valid gapped (pair every 3rd cycle) for (3,3),(3,3,last) -> bubbles drive mac_x=mac_y=0; out_mac=18, out_count=2.
- out_ready held 0 for 10 cycles in DONE while the next vector (5,5,last) is pushed -> out_mac=33 stays stable. After the handshake, the next result is out_mac=25, i.e. the MAC was cleared.
- reset pulled low during RUN of (9,9),(9,9),(9,9,last) after one pop -> all outputs take reset values immediately; no out_valid follows; a subsequent vector (1,2,last) gives out_mac=2, out_count=1.
